// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the round-robin stream multiplexer.
package mux_pkg;

    typedef enum logic {ARB, LOCK} arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter; the lowest request at or above ptr wins, wrapping.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [NUM_CH-1:0] rot;
    logic [CH_W-1:0]   off;
    logic [CH_W:0]     sum;

    // Rotating the doubled vector puts channel ptr at bit 0, so a plain priority encode is fair.
    always_comb begin
        rot = NUM_CH'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (rot[i]) off = CH_W'(i);
    end

    assign sum       = {1'b0, ptr} + {1'b0, off};
    assign grant_idx = (sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum - (CH_W+1)'(NUM_CH)) : sum[CH_W-1:0];
    assign grant     = (|req) ? NUM_CH'(1) << grant_idx : '0;

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: round-robin N:1 valid/ready stream mux with one output register stage
// and optional packet lock that holds the grant from first beat to last.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter bit LOCK_PKT = 1'b1,
    localparam int CH_W = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    arb_state_e        state, state_next;
    logic [CH_W-1:0]   ptr, lock_ch, arb_idx, win;
    logic [NUM_CH-1:0] arb_grant, grant;
    logic              ld, acc, sel_last;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign ld       = !out_valid || out_ready;
    assign in_ready = ld ? grant : '0;
    assign acc      = |(in_valid & in_ready);
    assign sel_last = in_last[win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state <= state_next;
            if (acc) lock_ch <= win;
            if (acc && (!LOCK_PKT || sel_last))
                ptr <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
    end

    // Any accepted beat decides the next state: a last beat closes (or is) a packet.
    always_comb begin
        state_next = (LOCK_PKT && acc) ? (sel_last ? ARB : LOCK) : state;
    end

    // While locked only the locked channel may be granted, and only when it is valid.
    always_comb begin
        win   = (state == LOCK) ? lock_ch : arb_idx;
        grant = (state == LOCK) ? (NUM_CH'(1) << lock_ch) & in_valid : arb_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (ld) begin
            out_valid <= acc;
            if (acc) begin
                out_data <= in_data[win*DATA_W +: DATA_W];
                out_last <= sel_last;
                out_ch   <= win;
            end
        end
    end

endmodule
